// File: rtl/regfile_ckpt_pkg.sv
// Shared types for the rename/dispatch/ROB blocks: producer tag and busy/tag map entry.
package regfile_ckpt_pkg;

  localparam int unsigned TagWidth  = 5;
  localparam int unsigned CkptSlots = 4;

  typedef logic [TagWidth-1:0] tag_t;

  typedef struct packed {
    logic busy;
    tag_t tag;
  } map_entry_t;

endpackage

// File: rtl/regfile_ckpt_ckpt_alloc.sv
// Checkpoint slot allocator: free mask, lowest-free encoder, full flag and save_ok register.
module regfile_ckpt_ckpt_alloc
  import regfile_ckpt_pkg::*;
#(
  parameter int unsigned NCKPT = CkptSlots,
  localparam int unsigned CW   = $clog2(NCKPT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             save_en,
  input  logic             restore_en,
  input  logic [CW-1:0]    restore_id,
  input  logic             free_en,
  input  logic [CW-1:0]    free_id,
  output logic [CW-1:0]    save_id,
  output logic             full,
  output logic             save_ok,
  output logic             save_accept,
  output logic [NCKPT-1:0] used
);

  logic [NCKPT-1:0] used_q, used_d;
  logic             save_ok_q;
  logic             found;

  // Allocation looks at the mask before this cycle's free/restore.
  always_comb begin
    save_id = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(NCKPT); i++) begin
      if (!used_q[i] && !found) begin
        save_id = CW'(i);
        found   = 1'b1;
      end
    end
  end

  assign full        = &used_q;
  assign save_accept = save_en && !full && !restore_en && !flush;

  always_comb begin
    used_d = used_q;
    if (flush) begin
      used_d = '0;
    end else begin
      if (free_en)     used_d[free_id]    = 1'b0;
      if (restore_en)  used_d[restore_id] = 1'b0;
      if (save_accept) used_d[save_id]    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      used_q    <= '0;
      save_ok_q <= 1'b0;
    end else begin
      used_q    <= used_d;
      save_ok_q <= save_accept;
    end
  end

  assign save_ok = save_ok_q;
  assign used    = used_q;

endmodule

// File: rtl/regfile_ckpt.sv
// Rename-aware register file with same-cycle bypass and busy/tag map checkpoints.
module regfile_ckpt
  import regfile_ckpt_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned TAG_W = TagWidth,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NCKPT = CkptSlots,
  localparam int unsigned RW   = $clog2(NREG),
  localparam int unsigned CW   = $clog2(NCKPT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 commit_en,
  input  logic [RW-1:0]        commit_id,
  input  logic [TAG_W-1:0]     commit_tag,
  input  logic [XLEN-1:0]      commit_val,
  input  logic                 rename_en,
  input  logic [RW-1:0]        rename_reg,
  input  logic [TAG_W-1:0]     rename_tag,
  input  logic [NRD*RW-1:0]    rd_id,
  output logic [NRD-1:0]       rd_busy,
  output logic [NRD*TAG_W-1:0] rd_tag,
  output logic [NRD*XLEN-1:0]  rd_val,
  input  logic                 ckpt_save_en,
  output logic [CW-1:0]        ckpt_save_id,
  output logic                 ckpt_save_ok,
  output logic                 ckpt_full,
  input  logic                 ckpt_restore_en,
  input  logic [CW-1:0]        ckpt_restore_id,
  input  logic                 ckpt_free_en,
  input  logic [CW-1:0]        ckpt_free_id
);

  logic [XLEN-1:0]  val_q  [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [TAG_W-1:0] tag_d  [NREG];
  logic [NREG-1:0]  sbusy_q [NCKPT];
  logic [NREG-1:0]  sbusy_d [NCKPT];
  logic [TAG_W-1:0] stag_q  [NCKPT][NREG];
  logic [TAG_W-1:0] stag_d  [NCKPT][NREG];

  logic             save_accept;
  logic [NCKPT-1:0] used;
  logic             commit_nz, rename_nz, commit_hit, restore_hit;

  regfile_ckpt_ckpt_alloc #(.NCKPT(NCKPT)) u_alloc (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .save_en    (ckpt_save_en),
    .restore_en (ckpt_restore_en),
    .restore_id (ckpt_restore_id),
    .free_en    (ckpt_free_en),
    .free_id    (ckpt_free_id),
    .save_id    (ckpt_save_id),
    .full       (ckpt_full),
    .save_ok    (ckpt_save_ok),
    .save_accept(save_accept),
    .used       (used)
  );

  assign commit_nz   = commit_en && (commit_id != '0);
  assign rename_nz   = rename_en && (rename_reg != '0);
  assign commit_hit  = commit_nz && busy_q[commit_id] && (tag_q[commit_id] == commit_tag);
  assign restore_hit = ckpt_restore_en && used[ckpt_restore_id] && !flush;

  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    if (flush) begin
      busy_d = '0;
    end else if (restore_hit) begin
      busy_d = sbusy_q[ckpt_restore_id];
      tag_d  = stag_q[ckpt_restore_id];
      if (commit_nz && busy_d[commit_id] && (tag_d[commit_id] == commit_tag)) begin
        busy_d[commit_id] = 1'b0;
      end
    end else begin
      if (commit_hit) busy_d[commit_id] = 1'b0;
      if (rename_nz) begin
        busy_d[rename_reg] = 1'b1;
        tag_d[rename_reg]  = rename_tag;
      end
    end
  end

  // A saved slot captures the live map as it will look after this edge.
  always_comb begin
    for (int s = 0; s < int'(NCKPT); s++) begin
      sbusy_d[s] = sbusy_q[s];
      stag_d[s]  = stag_q[s];
      if (flush) begin
        sbusy_d[s] = '0;
      end else if (save_accept && (ckpt_save_id == CW'(s))) begin
        sbusy_d[s] = busy_d;
        stag_d[s]  = tag_d;
      end else if (commit_nz && sbusy_q[s][commit_id] &&
                   (stag_q[s][commit_id] == commit_tag)) begin
        sbusy_d[s][commit_id] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      for (int r = 0; r < int'(NREG); r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
      for (int s = 0; s < int'(NCKPT); s++) begin
        sbusy_q[s] <= '0;
        for (int r = 0; r < int'(NREG); r++) stag_q[s][r] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      tag_q   <= tag_d;
      sbusy_q <= sbusy_d;
      stag_q  <= stag_d;
      if (commit_nz) val_q[commit_id] <= commit_val;
    end
  end

  always_comb begin
    for (int p = 0; p < int'(NRD); p++) begin
      logic [RW-1:0] id;
      id = rd_id[p*RW +: RW];
      rd_busy[p]              = busy_q[id];
      rd_tag[p*TAG_W +: TAG_W] = tag_q[id];
      rd_val[p*XLEN +: XLEN]   = val_q[id];
      if (commit_hit && (commit_id == id)) begin
        rd_busy[p]            = 1'b0;
        rd_val[p*XLEN +: XLEN] = commit_val;
      end
      if (rename_nz && (rename_reg == id)) begin
        rd_busy[p]              = 1'b1;
        rd_tag[p*TAG_W +: TAG_W] = rename_tag;
      end
    end
  end

endmodule

// File: tb/tb_regfile_ckpt.sv
// Directed-vector bench for regfile_ckpt with hand-computed expectations.
module tb_regfile_ckpt;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        commit_en;
  logic [4:0]  commit_id;
  logic [4:0]  commit_tag;
  logic [31:0] commit_val;
  logic        rename_en;
  logic [4:0]  rename_reg;
  logic [4:0]  rename_tag;
  logic [9:0]  rd_id;
  logic [1:0]  rd_busy;
  logic [9:0]  rd_tag;
  logic [63:0] rd_val;
  logic        ckpt_save_en;
  logic [1:0]  ckpt_save_id;
  logic        ckpt_save_ok;
  logic        ckpt_full;
  logic        ckpt_restore_en;
  logic [1:0]  ckpt_restore_id;
  logic        ckpt_free_en;
  logic [1:0]  ckpt_free_id;

  int checks = 0;
  int errors = 0;

  regfile_ckpt dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .commit_en      (commit_en),
    .commit_id      (commit_id),
    .commit_tag     (commit_tag),
    .commit_val     (commit_val),
    .rename_en      (rename_en),
    .rename_reg     (rename_reg),
    .rename_tag     (rename_tag),
    .rd_id          (rd_id),
    .rd_busy        (rd_busy),
    .rd_tag         (rd_tag),
    .rd_val         (rd_val),
    .ckpt_save_en   (ckpt_save_en),
    .ckpt_save_id   (ckpt_save_id),
    .ckpt_save_ok   (ckpt_save_ok),
    .ckpt_full      (ckpt_full),
    .ckpt_restore_en(ckpt_restore_en),
    .ckpt_restore_id(ckpt_restore_id),
    .ckpt_free_en   (ckpt_free_en),
    .ckpt_free_id   (ckpt_free_id)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    flush = 0; commit_en = 0; commit_id = 0; commit_tag = 0; commit_val = 0;
    rename_en = 0; rename_reg = 0; rename_tag = 0;
    ckpt_save_en = 0; ckpt_restore_en = 0; ckpt_restore_id = 0;
    ckpt_free_en = 0; ckpt_free_id = 0;
  endtask

  // Advance one edge; inputs are changed 1 ns after it, checks 1 ns later still.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a, input logic [4:0] b);
    rd_id = {b, a};
    #1;
  endtask

  task automatic do_commit(input logic [4:0] id, input logic [4:0] tg, input logic [31:0] v);
    commit_en = 1; commit_id = id; commit_tag = tg; commit_val = v;
  endtask

  task automatic do_rename(input logic [4:0] r, input logic [4:0] tg);
    rename_en = 1; rename_reg = r; rename_tag = tg;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0;
    rd_id = 0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    tick();

    // Reset state
    set_rd(5, 0);
    check_eq("rst_x5_busy", rd_busy[0], 0);
    check_eq("rst_x5_val", rd_val[31:0], 0);
    check_eq("rst_x0_busy", rd_busy[1], 0);
    check_eq("rst_x0_val", rd_val[63:32], 0);
    check_eq("rst_save_ok", ckpt_save_ok, 0);
    check_eq("rst_full", ckpt_full, 0);
    check_eq("rst_save_id", ckpt_save_id, 0);

    // Commit to non-busy x5: no bypass this cycle, visible next
    do_commit(5, 3, 32'hDEADBEEF);
    set_rd(5, 0);
    check_eq("x5_nobypass_val", rd_val[31:0], 0);
    tick(); idle();
    set_rd(5, 0);
    check_eq("x5_val", rd_val[31:0], 32'hDEADBEEF);
    check_eq("x5_busy", rd_busy[0], 0);

    // Rename x7 then stale commit, then matching commit
    do_rename(7, 4);
    set_rd(7, 0);
    check_eq("x7_ren_byp_busy", rd_busy[0], 1);
    check_eq("x7_ren_byp_tag", rd_tag[4:0], 4);
    tick(); idle();
    do_commit(7, 2, 32'h77);
    set_rd(7, 0);
    check_eq("x7_stale_busy", rd_busy[0], 1);
    tick(); idle();
    set_rd(7, 0);
    check_eq("x7_stale_busy_n", rd_busy[0], 1);
    check_eq("x7_stale_val", rd_val[31:0], 32'h77);
    do_commit(7, 4, 32'h78);
    set_rd(0, 7);
    check_eq("x7_match_byp_busy", rd_busy[1], 0);
    check_eq("x7_match_byp_val", rd_val[63:32], 32'h78);
    tick(); idle();
    set_rd(0, 7);
    check_eq("x7_match_busy", rd_busy[1], 0);
    check_eq("x7_match_val", rd_val[63:32], 32'h78);

    // Rename wins over same-cycle tag-matched commit on x9
    do_rename(9, 1);
    tick(); idle();
    do_rename(9, 6);
    do_commit(9, 1, 32'h55);
    set_rd(9, 9);
    check_eq("x9_byp_busy", rd_busy[0], 1);
    check_eq("x9_byp_tag", rd_tag[9:5], 6);
    check_eq("x9_byp_val", rd_val[31:0], 32'h55);
    tick(); idle();
    set_rd(9, 0);
    check_eq("x9_val", rd_val[31:0], 32'h55);
    check_eq("x9_busy", rd_busy[0], 1);
    check_eq("x9_tag", rd_tag[4:0], 6);

    // Register 0 ignores rename and commit
    do_rename(0, 7);
    do_commit(0, 0, 32'h99);
    set_rd(0, 0);
    check_eq("x0_byp_busy", rd_busy[0], 0);
    check_eq("x0_byp_val", rd_val[31:0], 0);
    tick(); idle();
    set_rd(0, 0);
    check_eq("x0_busy", rd_busy[0], 0);
    check_eq("x0_tag", rd_tag[4:0], 0);
    check_eq("x0_val", rd_val[31:0], 0);

    // Checkpoint save / rename / commit into slot / restore
    do_rename(3, 8);
    tick(); idle();
    ckpt_save_en = 1;
    #1 check_eq("save0_id", ckpt_save_id, 0);
    tick(); idle();
    #1;
    check_eq("save0_ok", ckpt_save_ok, 1);
    check_eq("save0_next_id", ckpt_save_id, 1);
    do_rename(3, 9);
    tick(); idle();
    #1 check_eq("save_ok_pulse", ckpt_save_ok, 0);
    do_commit(3, 8, 32'h33);
    set_rd(3, 0);
    check_eq("x3_live_busy", rd_busy[0], 1);
    check_eq("x3_live_tag", rd_tag[4:0], 9);
    tick(); idle();
    ckpt_restore_en = 1; ckpt_restore_id = 0;
    tick(); idle();
    set_rd(3, 9);
    check_eq("x3_restored_busy", rd_busy[0], 0);
    check_eq("x9_restored_busy", rd_busy[1], 1);
    check_eq("x9_restored_tag", rd_tag[9:5], 6);
    check_eq("restore_freed_id", ckpt_save_id, 0);

    // Fill all four slots, then a rejected fifth save
    ckpt_save_en = 1;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq($sformatf("fill_id%0d", i), ckpt_save_id, i);
      tick();
    end
    #1;
    check_eq("full_set", ckpt_full, 1);
    check_eq("fill_ok", ckpt_save_ok, 1);
    tick(); idle();
    #1;
    check_eq("reject_ok", ckpt_save_ok, 0);
    check_eq("reject_full", ckpt_full, 1);
    ckpt_free_en = 1; ckpt_free_id = 2;
    #1 check_eq("free_same_cycle_full", ckpt_full, 1);
    tick(); idle();
    #1;
    check_eq("free_save_id", ckpt_save_id, 2);
    check_eq("free_full", ckpt_full, 0);

    // Flush with slots live and registers busy; commit value still lands
    do_rename(10, 11);
    tick(); idle();
    flush = 1;
    do_commit(4, 0, 32'h11);
    tick(); idle();
    set_rd(10, 4);
    check_eq("flush_x10_busy", rd_busy[0], 0);
    check_eq("flush_x4_busy", rd_busy[1], 0);
    check_eq("flush_x4_val", rd_val[63:32], 32'h11);
    set_rd(9, 0);
    check_eq("flush_x9_busy", rd_busy[0], 0);
    check_eq("flush_full", ckpt_full, 0);
    check_eq("flush_save_id", ckpt_save_id, 0);

    // Restoring a free slot leaves the live map alone
    do_rename(6, 3);
    tick(); idle();
    ckpt_restore_en = 1; ckpt_restore_id = 1;
    tick(); idle();
    set_rd(6, 0);
    check_eq("restore_free_busy", rd_busy[0], 1);
    check_eq("restore_free_tag", rd_tag[4:0], 3);

    // Mid-sequence asynchronous reset clears immediately
    ckpt_save_en = 1;
    tick(); idle();
    #1 check_eq("pre_rst_ok", ckpt_save_ok, 1);
    rst = 0;
    set_rd(4, 6);
    check_eq("arst_x4_val", rd_val[31:0], 0);
    check_eq("arst_x6_busy", rd_busy[1], 0);
    check_eq("arst_save_ok", ckpt_save_ok, 0);
    check_eq("arst_save_id", ckpt_save_id, 0);
    set_rd(5, 0);
    check_eq("arst_x5_val", rd_val[31:0], 0);
    tick();
    rst = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
